// File: rtl/rob_ctrl_pkg.sv
// Shared sizing, exception vector and sequencing-state encoding for the ROB controller.
package rob_ctrl_pkg;
  localparam int unsigned ROB_SLOTS    = 16;
  localparam int unsigned ROB_IDX_BITS = 4;
  localparam int unsigned ARCH_BITS    = 32;
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_2000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;
endpackage

// File: rtl/rob_ctrl_ptr_ctr.sv
// Mod-2^W ring pointer with increment and synchronous clear; used for ROB head and tail.
module rob_ptr_ctr #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)      ptr_d = '0;
    else if (inc) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/rob_ctrl.sv
// ROB sequencing controller: in-order slot allocation, occupancy tracking and
// the exception flush / fetch-redirect sequence.
module rob_ctrl
  import rob_ctrl_pkg::*;
#(
  parameter int unsigned ROB_SLOTS    = rob_ctrl_pkg::ROB_SLOTS,
  parameter int unsigned ROB_IDX_BITS = rob_ctrl_pkg::ROB_IDX_BITS,
  parameter int unsigned ARCH_BITS    = rob_ctrl_pkg::ARCH_BITS,
  parameter logic [ARCH_BITS-1:0] EXC_VECTOR = rob_ctrl_pkg::EXC_VECTOR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_req,
  output logic                    alloc_gnt,
  output logic [ROB_IDX_BITS-1:0] alloc_idx,
  output logic                    stall,
  input  logic                    commit_valid,
  input  logic                    commit_except,
  input  logic [ARCH_BITS-1:0]    commit_pc,
  input  logic [ARCH_BITS-1:0]    commit_addr,
  output logic                    rob_clear,
  output logic                    redirect_valid,
  output logic [ARCH_BITS-1:0]    redirect_pc,
  output logic [ARCH_BITS-1:0]    epc,
  output logic [ARCH_BITS-1:0]    ebadaddr,
  output logic [ROB_IDX_BITS:0]   count,
  output logic                    full,
  output logic                    empty
);
  localparam logic [ROB_IDX_BITS:0] FULL_CNT = (ROB_IDX_BITS+1)'(ROB_SLOTS);

  state_e                  state_q, state_d;
  logic [ROB_IDX_BITS:0]   count_q, count_d;
  logic [ARCH_BITS-1:0]    epc_q, ebad_q;
  logic                    rob_clear_q, redirect_q;
  logic [ROB_IDX_BITS-1:0] head, tail;
  logic                    eff_commit, exc_commit, retire, ptr_clr;

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign eff_commit = (state_q == ST_RUN) && commit_valid && !empty;
  assign exc_commit = eff_commit && commit_except;
  assign retire     = eff_commit && !commit_except;
  // Pointers/count are zeroed on the excepting commit itself (so FLUSH already
  // shows count==0) and held at zero through FLUSH and REDIRECT.
  assign ptr_clr    = (state_q != ST_RUN) || exc_commit;

  rob_ptr_ctr #(.W(ROB_IDX_BITS)) u_tail (
    .clk(clk), .rst(rst), .clr(ptr_clr), .inc(alloc_gnt), .ptr(tail)
  );
  rob_ptr_ctr #(.W(ROB_IDX_BITS)) u_head (
    .clk(clk), .rst(rst), .clr(ptr_clr), .inc(retire), .ptr(head)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (exc_commit) state_d = ST_FLUSH;
      ST_FLUSH:    state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_comb begin
    alloc_gnt = 1'b0;
    stall     = 1'b1;
    if (state_q == ST_RUN) begin
      alloc_gnt = alloc_req && !full && !exc_commit;
      stall     = full;
    end
  end

  always_comb begin
    count_d = count_q;
    if (ptr_clr)                 count_d = '0;
    else if (alloc_gnt && !retire) count_d = count_q + 1'b1;
    else if (!alloc_gnt && retire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      epc_q       <= '0;
      ebad_q      <= '0;
      rob_clear_q <= 1'b0;
      redirect_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      rob_clear_q <= (state_d == ST_FLUSH);
      redirect_q  <= (state_d == ST_REDIRECT);
      if (exc_commit) begin
        epc_q  <= commit_pc;
        ebad_q <= commit_addr;
      end
    end
  end

  assign alloc_idx      = tail;
  assign count          = count_q;
  assign rob_clear      = rob_clear_q;
  assign redirect_valid = redirect_q;
  assign redirect_pc    = EXC_VECTOR;
  assign epc            = epc_q;
  assign ebadaddr       = ebad_q;

  logic unused_head;
  assign unused_head = ^head;
endmodule

// File: tb/tb_rob_ctrl.sv
// Self-checking bench for rob_ctrl: directed scenarios then randomized traffic,
// compared against a queue-based model of the ROB occupancy and flush sequence.
module tb_rob_ctrl;
  logic        clk = 1'b0;
  logic        rst, alloc_req, commit_valid, commit_except;
  logic [31:0] commit_pc, commit_addr;
  logic        alloc_gnt, stall, rob_clear, redirect_valid, full, empty;
  logic [3:0]  alloc_idx;
  logic [31:0] redirect_pc, epc, ebadaddr;
  logic [4:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the ROB is a queue of outstanding slot indices.
  int          q[$];
  int          next_idx = 0;
  int          phase    = 0;   // 0 run, 1 flushing, 2 redirecting
  logic [31:0] m_epc = '0, m_bad = '0;
  logic        m_clear = 1'b0, m_redir = 1'b0;

  always #5 clk = ~clk;

  rob_ctrl u_dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx), .stall(stall),
    .commit_valid(commit_valid), .commit_except(commit_except),
    .commit_pc(commit_pc), .commit_addr(commit_addr),
    .rob_clear(rob_clear), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .epc(epc), .ebadaddr(ebadaddr), .count(count), .full(full), .empty(empty)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic req, input logic cv, input logic exc,
                      input logic [31:0] pc, input logic [31:0] addr);
    bit e_full, e_empty, e_gnt, eff;
    @(negedge clk);
    rst = r; alloc_req = req; commit_valid = cv; commit_except = exc;
    commit_pc = pc; commit_addr = addr;
    #1;
    e_full  = (q.size() == 16);
    e_empty = (q.size() == 0);
    eff     = (phase == 0) && cv && !e_empty;
    e_gnt   = (phase == 0) && req && !e_full && !(eff && exc);
    check("count", count, q.size());
    check("full", full, e_full);
    check("empty", empty, e_empty);
    check("stall", stall, e_full || phase != 0);
    check("alloc_gnt", alloc_gnt, e_gnt);
    if (e_gnt) check("alloc_idx", alloc_idx, next_idx);
    check("rob_clear", rob_clear, m_clear);
    check("redirect_valid", redirect_valid, m_redir);
    if (m_redir) check("redirect_pc", redirect_pc, 32'h0000_2000);
    check("epc", epc, m_epc);
    check("ebadaddr", ebadaddr, m_bad);
    @(posedge clk);
    if (r) begin
      q.delete(); next_idx = 0; phase = 0;
      m_epc = '0; m_bad = '0;
    end else if (phase == 0) begin
      if (eff && exc) begin
        m_epc = pc; m_bad = addr;
        q.delete(); next_idx = 0; phase = 1;
      end else begin
        if (eff) void'(q.pop_front());
        if (e_gnt) begin
          q.push_back(next_idx);
          next_idx = (next_idx + 1) % 16;
        end
      end
    end else begin
      phase = (phase == 1) ? 2 : 0;
    end
    m_clear = (phase == 1);
    m_redir = (phase == 2);
  endtask

  initial begin
    rst = 1'b1; alloc_req = 1'b0; commit_valid = 1'b0; commit_except = 1'b0;
    commit_pc = '0; commit_addr = '0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Fill to 16, then one more request that must be refused.
    for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);                       // full: commit does not free slot this cycle
    step(0, 1, 0, 0, 0, 0);                       // grant wraps to index 0
    for (int i = 0; i < 13; i++) step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 0);   // drain plus commits while empty
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 32'h104, 32'hDEAD_0000);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    check("epc_directed", epc, 32'h104);
    check("ebad_directed", ebadaddr, 32'hDEAD_0000);
    // Reset asserted while in FLUSH.
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32'h200, 32'h55);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Randomized traffic with shifting alloc/commit bias.
    for (int i = 0; i < 3000; i++) begin
      int unsigned pa, pc_;
      pa  = 20 + 30 * ((i / 200) % 3);
      pc_ = 80 - 30 * ((i / 200) % 3);
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 99) < pa,
           $urandom_range(0, 99) < pc_,
           $urandom_range(0, 39) == 0,
           $urandom, $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
